// File: rtl/icache_interco_pkg.sv
// Shared types and helpers for the icache SCM interconnect response path.
package icache_interco_pkg;

    localparam int DEF_ID_WIDTH   = 3;
    localparam int DEF_DATA_WIDTH = 32;

    // Width of an occupancy counter that must be able to hold the value depth itself.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] rdata;
    } resp_beat_t;

endpackage

// File: rtl/id_fifo_scm.sv
// In-order FIFO of master indices; depth need not be a power of two.
module id_fifo_scm
    import icache_interco_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_id,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // NOTE: storage is not reset; count gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_id;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_id = mem[rd_ptr];
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);

endmodule

// File: rtl/rr_resp_route_scm.sv
// Routes in-order bank responses back to the master that won each grant.
module rr_resp_route_scm
    import icache_interco_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int N_MASTERS  = 2**WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    input  logic [WIDTH-1:0]      data_id_i,
    input  logic                  data_gnt_i,
    output logic                  data_gnt_o,
    input  logic                  r_valid_i,
    input  logic [DATA_WIDTH-1:0] r_rdata_i,
    output logic [N_MASTERS-1:0]  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic [WIDTH-1:0]      r_id_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  err_o
);

    typedef struct packed {
        logic [WIDTH-1:0]      id;
        logic [DATA_WIDTH-1:0] rdata;
    } beat_t;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] pop_id;
    logic [N_MASTERS-1:0] onehot;
    beat_t            beat;

    // A pop in the same cycle does not free a slot for the grant: full blocks unconditionally.
    assign data_gnt_o = data_gnt_i & ~full;
    assign push       = data_req_i & data_gnt_o;
    assign pop        = r_valid_i & ~empty;

    id_fifo_scm #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .push_id (data_id_i),
        .pop     (pop),
        .pop_id  (pop_id),
        .full    (full),
        .empty   (empty)
    );

    // NOTE: default first so every path assigns onehot and no latch is inferred.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            onehot[i] = (pop_id == WIDTH'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_o <= '0;
            beat      <= '0;
            err_o     <= 1'b0;
        end else begin
            r_valid_o <= pop ? onehot : '0;
            if (pop) beat <= '{id: pop_id, rdata: r_rdata_i};
            if (r_valid_i && empty) err_o <= 1'b1;
        end
    end

    assign r_rdata_o = beat.rdata;
    assign r_id_o    = beat.id;
    assign full_o    = full;
    assign empty_o   = empty;

endmodule

// File: tb/tb_rr_resp_route_scm.sv
// Self-checking bench: depth-4 and depth-3 instances driven in lockstep against an ordered-list model.
module tb_rr_resp_route_scm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req_i = 1'b0;
    logic [2:0]  data_id_i = '0;
    logic        data_gnt_i = 1'b0;
    logic        r_valid_i = 1'b0;
    logic [31:0] r_rdata_i = '0;

    logic        o_gnt   [2];
    logic [7:0]  o_rv    [2];
    logic [31:0] o_rd    [2];
    logic [2:0]  o_id    [2];
    logic        o_empty [2];
    logic        o_full  [2];
    logic        o_err   [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model: every accepted id is appended to an ever-growing list; head/tail never wrap.
    int          ids [2][4096];
    int          head [2];
    int          tail [2];
    logic        m_err [2];
    logic [7:0]  m_rv  [2];
    logic [31:0] m_rd  [2];
    logic [2:0]  m_id  [2];
    logic        pre_gnt [2];
    logic        exp_gnt [2];

    always #5 clk = ~clk;

    rr_resp_route_scm #(.WIDTH(3), .FIFO_DEPTH(4), .DATA_WIDTH(32)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_req_i(data_req_i), .data_id_i(data_id_i),
        .data_gnt_i(data_gnt_i), .data_gnt_o(o_gnt[0]), .r_valid_i(r_valid_i),
        .r_rdata_i(r_rdata_i), .r_valid_o(o_rv[0]), .r_rdata_o(o_rd[0]), .r_id_o(o_id[0]),
        .empty_o(o_empty[0]), .full_o(o_full[0]), .err_o(o_err[0])
    );

    rr_resp_route_scm #(.WIDTH(3), .FIFO_DEPTH(3), .DATA_WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_req_i(data_req_i), .data_id_i(data_id_i),
        .data_gnt_i(data_gnt_i), .data_gnt_o(o_gnt[1]), .r_valid_i(r_valid_i),
        .r_rdata_i(r_rdata_i), .r_valid_o(o_rv[1]), .r_rdata_o(o_rd[1]), .r_id_o(o_id[1]),
        .empty_o(o_empty[1]), .full_o(o_full[1]), .err_o(o_err[1])
    );

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int occ(input int k);
        return tail[k] - head[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            head[k] = 0; tail[k] = 0; m_err[k] = 1'b0;
            m_rv[k] = '0; m_rd[k] = '0; m_id[k] = '0;
        end
    endtask

    task automatic apply_reset();
        data_req_i = 1'b0; data_gnt_i = 1'b0; r_valid_i = 1'b0;
        data_id_i = '0; r_rdata_i = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; leaves time at posedge+1 with the model advanced.
    task automatic step(input logic req, input logic [2:0] id, input logic gnt,
                        input logic rv, input logic [31:0] rd);
        data_req_i = req; data_id_i = id; data_gnt_i = gnt; r_valid_i = rv; r_rdata_i = rd;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit is_full, is_empty, do_pop, do_push;
            int pid;
            is_full  = (occ(k) == depth_of(k));
            is_empty = (occ(k) == 0);
            pre_gnt[k] = o_gnt[k];
            exp_gnt[k] = gnt && !is_full;
            do_pop  = rv && !is_empty;
            do_push = req && gnt && !is_full;
            if (do_pop) begin
                pid = ids[k][head[k]];
                head[k]++;
                m_rv[k] = 8'h01 << pid;
                m_rd[k] = rd;
                m_id[k] = 3'(pid);
            end else begin
                m_rv[k] = '0;
            end
            if (do_push) begin
                ids[k][tail[k]] = int'(id);
                tail[k]++;
            end
            if (rv && is_empty) m_err[k] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        data_gnt_i = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_rv[k] !== 8'h00 || o_rd[k] !== 32'h0 || o_id[k] !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_resp[%0d]: got rv=%h rd=%h id=%0d, want 00/0/0", k, o_rv[k], o_rd[k], o_id[k]);
            end
            n_checks++;
            if (o_err[k] !== 1'b0 || o_full[k] !== 1'b0 || o_empty[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_flags[%0d]: got err=%b full=%b empty=%b, want 0/0/1", k, o_err[k], o_full[k], o_empty[k]);
            end
            n_checks++;
            if (o_gnt[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_gnt[%0d]: got %b, want 1", k, o_gnt[k]);
            end
        end
        data_gnt_i = 1'b0;
    endtask

    task automatic test_order();
        logic [7:0]  want_oh [3] = '{8'h20, 8'h04, 8'h80};
        logic [31:0] dat     [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        apply_reset();
        step(1, 3'd5, 1, 0, '0);
        step(1, 3'd2, 1, 0, '0);
        step(1, 3'd7, 1, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 1, dat[i]);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_rv[k] !== want_oh[i] || o_rd[k] !== dat[i]) begin
                    n_errors++;
                    $display("FAIL order_beat%0d[%0d]: got rv=%h rd=%h, want rv=%h rd=%h", i, k, o_rv[k], o_rd[k], want_oh[i], dat[i]);
                end
            end
        end
        n_checks++;
        if (o_empty[0] !== 1'b1 || o_empty[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL order_empty: got %b/%b, want 1/1", o_empty[0], o_empty[1]);
        end
        step(0, '0, 0, 0, '0);
        n_checks++;
        if (o_rv[0] !== 8'h00 || o_rd[0] !== dat[2] || o_id[0] !== 3'd7) begin
            n_errors++;
            $display("FAIL order_hold: got rv=%h rd=%h id=%0d, want 00/%h/7", o_rv[0], o_rd[0], o_id[0], dat[2]);
        end
    endtask

    task automatic test_fill();
        logic [2:0] want_ids [4] = '{3'd1, 3'd2, 3'd3, 3'd6};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 3'(i), 1, 0, '0);
            if (i == 2) begin
                n_checks++;
                if (o_full[0] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fill_early_full: got %b, want 0", o_full[0]);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (o_full[0] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL fill_full: got %b, want 1", o_full[0]);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (pre_gnt[0] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fill_gnt5: got %b, want 0", pre_gnt[0]);
                end
            end
        end
        // Full with simultaneous pop and request: pop proceeds, push is still blocked.
        step(1, 3'd6, 1, 1, 32'h1234_5678);
        n_checks++;
        if (pre_gnt[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL fullpop_gnt: got %b, want 0", pre_gnt[0]);
        end
        n_checks++;
        if (o_rv[0] !== 8'h01 || o_full[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL fullpop_resp: got rv=%h full=%b, want 01/0", o_rv[0], o_full[0]);
        end
        step(1, 3'd6, 1, 0, '0);
        n_checks++;
        if (pre_gnt[0] !== 1'b1 || o_full[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL refill: got gnt=%b full=%b, want 1/1", pre_gnt[0], o_full[0]);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 0, 1, 32'(i));
            n_checks++;
            if (o_id[0] !== want_ids[i] || o_rv[0] !== (8'h01 << want_ids[i])) begin
                n_errors++;
                $display("FAIL drain%0d: got id=%0d rv=%h, want id=%0d", i, o_id[0], o_rv[0], want_ids[i]);
            end
        end
        n_checks++;
        if (o_empty[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_empty: got %b, want 1", o_empty[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] prev, nxt;
        apply_reset();
        prev = 3'($urandom_range(0, 7));
        step(1, prev, 1, 0, '0);
        for (int c = 0; c < 20; c++) begin
            logic [31:0] d;
            nxt = 3'($urandom_range(0, 7));
            d = $urandom;
            step(1, nxt, 1, 1, d);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_id[k] !== prev || o_rv[k] !== (8'h01 << prev) || o_rd[k] !== d) begin
                    n_errors++;
                    $display("FAIL b2b_c%0d[%0d]: got id=%0d rv=%h rd=%h, want id=%0d rd=%h", c, k, o_id[k], o_rv[k], o_rd[k], prev, d);
                end
                n_checks++;
                if (o_empty[k] !== 1'b0 || o_full[k] !== 1'b0 || pre_gnt[k] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_occ_c%0d[%0d]: got empty=%b full=%b gnt=%b, want 0/0/1", c, k, o_empty[k], o_full[k], pre_gnt[k]);
                end
            end
            prev = nxt;
        end
    endtask

    task automatic test_err();
        apply_reset();
        step(1, 3'd1, 1, 1, 32'hDEAD_0000);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_err[k] !== 1'b1 || o_rv[k] !== 8'h00) begin
                n_errors++;
                $display("FAIL err_set[%0d]: got err=%b rv=%h, want 1/00", k, o_err[k], o_rv[k]);
            end
        end
        step(0, '0, 0, 1, 32'hBEEF_0001);
        step(0, '0, 0, 0, '0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_id[k] !== 3'd1 || o_rd[k] !== 32'hBEEF_0001 || o_err[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL err_next[%0d]: got id=%0d rd=%h err=%b, want 1/BEEF0001/1", k, o_id[k], o_rd[k], o_err[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(1, 3'd3, 1, 0, '0);
        step(1, 3'd4, 1, 0, '0);
        data_req_i = 1'b0; data_gnt_i = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_empty[k] !== 1'b1 || o_err[k] !== 1'b0 || o_rv[k] !== 8'h00) begin
                n_errors++;
                $display("FAIL midreset[%0d]: got empty=%b err=%b rv=%h, want 1/0/00", k, o_empty[k], o_err[k], o_rv[k]);
            end
        end
        step(0, '0, 0, 1, 32'h5555_AAAA);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_err[k] !== 1'b1 || o_rv[k] !== 8'h00) begin
                n_errors++;
                $display("FAIL midreset_err[%0d]: got err=%b rv=%h, want 1/00", k, o_err[k], o_rv[k]);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            logic req, gnt, rv;
            req = ($urandom_range(0, 99) < 70);
            gnt = ($urandom_range(0, 99) < 80);
            rv  = ($urandom_range(0, 99) < ((c % 100) < 50 ? 30 : 75));
            step(req, 3'($urandom_range(0, 7)), gnt, rv, $urandom);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pre_gnt[k] !== exp_gnt[k]) begin
                    n_errors++;
                    $display("FAIL rand_gnt c%0d[%0d]: got %b, want %b", c, k, pre_gnt[k], exp_gnt[k]);
                end
                n_checks++;
                if (o_rv[k] !== m_rv[k] || o_rd[k] !== m_rd[k] || o_id[k] !== m_id[k]) begin
                    n_errors++;
                    $display("FAIL rand_resp c%0d[%0d]: got rv=%h rd=%h id=%0d, want rv=%h rd=%h id=%0d", c, k, o_rv[k], o_rd[k], o_id[k], m_rv[k], m_rd[k], m_id[k]);
                end
                n_checks++;
                if (o_err[k] !== m_err[k] || o_full[k] !== (occ(k) == depth_of(k)) || o_empty[k] !== (occ(k) == 0)) begin
                    n_errors++;
                    $display("FAIL rand_flags c%0d[%0d]: got err=%b full=%b empty=%b, want err=%b occ=%0d", c, k, o_err[k], o_full[k], o_empty[k], m_err[k], occ(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_fill();
        test_back_to_back();
        test_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
